// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard and sequencing controller. Generates the stall/flush controls
// for the PC, IF/ID and ID/EX registers from the decode-stage operands, the
// ID/EX register outputs and the data-memory handshake. Handles load-use
// bubbles, EX-stage redirects and multi-cycle memory waits with a timeout.
// Keeps saturating stall/flush performance counters.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   id_rs1/id_rs2            decode-stage source register indices
//   id_uses_rs1/id_uses_rs2  decode instruction actually reads rs1/rs2
//   ex_rd, ex_reg_write      ID/EX destination register and write enable
//   ex_result_src            ID/EX result select (2'b01 = load)
//   ex_redirect              control-flow redirect resolved in EX
//   mem_req, dmem_ready      data-memory access and completion handshake
//   stall_pc, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex
//                            combinational pipeline controls
//   mem_timeout              sticky memory-timeout error
//   stall_cnt, flush_cnt     saturating stall-cycle / redirect-flush counters
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic [1:0]       ex_result_src,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             flush_if_id,
  output logic             stall_id_ex,
  output logic             flush_id_ex,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Timer only needs to reach MEM_TIMEOUT-1.
  localparam int TW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [TW-1:0]   timer_reg, timer_next;
  logic            mem_timeout_reg, mem_timeout_next;
  logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;
  logic [CNT_W-1:0] flush_cnt_reg, flush_cnt_next;

  logic load_use;
  logic s_pc, s_if_id, f_if_id, s_id_ex, f_id_ex;
  logic redirect_evt;

  // A load in EX whose destination is read by the instruction in decode.
  // x0 is never a real dependency.
  assign load_use = (ex_result_src == 2'b01) && ex_reg_write && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    state_next       = state_reg;
    timer_next       = timer_reg;
    mem_timeout_next = mem_timeout_reg;
    s_pc             = 1'b0;
    s_if_id          = 1'b0;
    f_if_id          = 1'b0;
    s_id_ex          = 1'b0;
    f_id_ex          = 1'b0;
    redirect_evt     = 1'b0;

    case (state_reg)
      ST_RUN: begin
        if (ex_redirect) begin
          // Redirect wins: the wrong-path instructions are squashed, so any
          // hazard they would have caused is moot.
          f_if_id      = 1'b1;
          f_id_ex      = 1'b1;
          redirect_evt = 1'b1;
        end else if (mem_req && !dmem_ready) begin
          s_pc       = 1'b1;
          s_if_id    = 1'b1;
          s_id_ex    = 1'b1;
          state_next = ST_MEM_WAIT;
          timer_next = TW'(1);
        end else if (load_use) begin
          // Hold decode, bubble into EX; the bubble has rd=0 so LU drops next cycle.
          s_pc    = 1'b1;
          s_if_id = 1'b1;
          f_id_ex = 1'b1;
        end
      end

      ST_MEM_WAIT: begin
        if (dmem_ready) begin
          state_next = ST_RUN;
          timer_next = '0;
        end else begin
          s_pc    = 1'b1;
          s_if_id = 1'b1;
          s_id_ex = 1'b1;
          if (timer_reg == TIMER_LAST) begin
            state_next       = ST_ERROR;
            mem_timeout_next = 1'b1;
          end else begin
            timer_next = timer_reg + TW'(1);
          end
        end
      end

      ST_ERROR: begin
        s_pc    = 1'b1;
        s_if_id = 1'b1;
        s_id_ex = 1'b1;
      end

      default: begin
        state_next = ST_RUN;
        timer_next = '0;
      end
    endcase
  end

  // Controls are forced low for the whole time reset is held.
  assign stall_pc    = s_pc    & ~rst;
  assign stall_if_id = s_if_id & ~rst;
  assign flush_if_id = f_if_id & ~rst;
  assign stall_id_ex = s_id_ex & ~rst;
  assign flush_id_ex = f_id_ex & ~rst;

  // Counters hold at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    flush_cnt_next = flush_cnt_reg;
    if (s_pc && (stall_cnt_reg != {CNT_W{1'b1}}))
      stall_cnt_next = stall_cnt_reg + CNT_W'(1);
    if (redirect_evt && (flush_cnt_reg != {CNT_W{1'b1}}))
      flush_cnt_next = flush_cnt_reg + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= ST_RUN;
      timer_reg       <= '0;
      mem_timeout_reg <= 1'b0;
      stall_cnt_reg   <= '0;
      flush_cnt_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      timer_reg       <= timer_next;
      mem_timeout_reg <= mem_timeout_next;
      stall_cnt_reg   <= stall_cnt_next;
      flush_cnt_reg   <= flush_cnt_next;
    end
  end

  assign mem_timeout = mem_timeout_reg;
  assign stall_cnt   = stall_cnt_reg;
  assign flush_cnt   = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 4;
  localparam int CMAX        = (1 << CNT_W) - 1;

  // Control vector order: {stall_pc, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex}
  localparam logic [4:0] C_NONE  = 5'b00000;
  localparam logic [4:0] C_STALL = 5'b11010;
  localparam logic [4:0] C_LU    = 5'b11001;
  localparam logic [4:0] C_FLUSH = 5'b00101;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_uses_rs1, id_uses_rs2, ex_reg_write, ex_redirect, mem_req, dmem_ready;
  logic [1:0] ex_result_src;
  logic stall_pc, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex, mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [4:0] ctl;

  int n_checks = 0;
  int n_fail   = 0;

  assign ctl = {stall_pc, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex};

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_result_src(ex_result_src),
    .ex_redirect(ex_redirect), .mem_req(mem_req), .dmem_ready(dmem_ready),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id), .flush_if_id(flush_if_id),
    .stall_id_ex(stall_id_ex), .flush_id_ex(flush_id_ex),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic [1:0] rsrc,
                       input logic redir, input logic mreq, input logic rdy);
    id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    ex_rd = rd; ex_reg_write = rw; ex_result_src = rsrc;
    ex_redirect = redir; mem_req = mreq; dmem_ready = rdy;
  endtask

  task automatic drive_idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if ({ctl, mem_timeout, stall_cnt, flush_cnt} !== {5'b0, 1'b0, {CNT_W{1'b0}}, {CNT_W{1'b0}}}) begin
      n_fail++;
      $display("FAIL reset_state: ctl=%b to=%b sc=%0d fc=%0d required all zero", ctl, mem_timeout, stall_cnt, flush_cnt);
    end
    $display("reset: ctl=%b to=%b sc=%0d fc=%0d", ctl, mem_timeout, stall_cnt, flush_cnt);
  endtask

  task automatic test_load_use();
    do_reset();
    @(negedge clk);
    drive(5'd5, 5'd9, 1'b1, 1'b0, 5'd5, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (ctl !== C_LU) begin
      n_fail++; $display("FAIL lu_ctrl: ctl=%b required %b", ctl, C_LU);
    end
    $display("load_use rs1 hit: ctl=%b", ctl);
    @(negedge clk);
    ex_rd = 5'd0;
    #1;
    n_checks++;
    if (ctl !== C_NONE || stall_cnt !== CNT_W'(1)) begin
      n_fail++; $display("FAIL lu_after: ctl=%b sc=%0d required %b sc=1", ctl, stall_cnt, C_NONE);
    end
    $display("load_use bubble: ctl=%b sc=%0d", ctl, stall_cnt);
    // rs2 match also triggers
    @(negedge clk);
    drive(5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (ctl !== C_LU) begin
      n_fail++; $display("FAIL lu_rs2: ctl=%b required %b", ctl, C_LU);
    end
    $display("load_use rs2 hit: ctl=%b", ctl);
  endtask

  task automatic test_no_hazard();
    logic [4:0] rds [3];
    logic       u1s [3];
    logic [1:0] srcs [3];
    rds  = '{5'd0, 5'd5, 5'd5};
    u1s  = '{1'b1, 1'b0, 1'b1};
    srcs = '{2'b01, 2'b01, 2'b00};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(5'd5, 5'd0, u1s[i], 1'b0, rds[i], 1'b1, srcs[i], 1'b0, 1'b0, 1'b0);
      #1;
      n_checks++;
      if (ctl !== C_NONE || stall_cnt !== '0 || flush_cnt !== '0) begin
        n_fail++; $display("FAIL no_hazard_%0d: ctl=%b sc=%0d fc=%0d required none/0/0", i, ctl, stall_cnt, flush_cnt);
      end
      $display("no_hazard case %0d: ctl=%b", i, ctl);
    end
  endtask

  task automatic test_redirect_priority();
    do_reset();
    @(negedge clk);
    drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (ctl !== C_FLUSH) begin
      n_fail++; $display("FAIL redirect_ctrl: ctl=%b required %b", ctl, C_FLUSH);
    end
    @(negedge clk);
    drive_idle();
    #1;
    n_checks++;
    if (flush_cnt !== CNT_W'(1) || stall_cnt !== '0 || ctl !== C_NONE) begin
      n_fail++; $display("FAIL redirect_cnt: fc=%0d sc=%0d ctl=%b required fc=1 sc=0 none", flush_cnt, stall_cnt, ctl);
    end
    $display("redirect priority: fc=%0d sc=%0d", flush_cnt, stall_cnt);
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, (i == 3));
      #1;
      n_checks++;
      if (ctl !== ((i == 3) ? C_NONE : C_STALL)) begin
        n_fail++; $display("FAIL mem_wait_c%0d: ctl=%b required %b", i, ctl, (i == 3) ? C_NONE : C_STALL);
      end
      $display("mem_wait cycle %0d: ctl=%b", i, ctl);
    end
    // Back in RUN: a load-use must be handled again, not a memory stall.
    @(negedge clk);
    drive(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (stall_cnt !== CNT_W'(3) || ctl !== C_LU || mem_timeout !== 1'b0) begin
      n_fail++; $display("FAIL mem_wait_end: sc=%0d ctl=%b to=%b required sc=3 %b to=0", stall_cnt, ctl, mem_timeout, C_LU);
    end
    $display("mem_wait done: sc=%0d", stall_cnt);
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 1; i <= MEM_TIMEOUT + 10; i++) begin
      @(negedge clk);
      // Redirect and load-use are asserted on purpose: must be ignored once waiting.
      drive(5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 2'b01, (i > 1), 1'b1, 1'b0);
      #1;
      n_checks++;
      if (ctl !== C_STALL || mem_timeout !== (i > MEM_TIMEOUT)) begin
        n_fail++; $display("FAIL timeout_c%0d: ctl=%b to=%b required %b to=%b", i, ctl, mem_timeout, C_STALL, (i > MEM_TIMEOUT));
      end
    end
    n_checks++;
    if (stall_cnt !== CNT_W'(MEM_TIMEOUT + 9) || flush_cnt !== '0) begin
      n_fail++; $display("FAIL timeout_cnt: sc=%0d fc=%0d required sc=%0d fc=0", stall_cnt, flush_cnt, MEM_TIMEOUT + 9);
    end
    $display("timeout: to=%b sc=%0d", mem_timeout, stall_cnt);
    // Asynchronous reset mid-cycle, between clock edges.
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({ctl, mem_timeout, stall_cnt, flush_cnt} !== '0) begin
      n_fail++; $display("FAIL async_reset: ctl=%b to=%b sc=%0d fc=%0d required all zero", ctl, mem_timeout, stall_cnt, flush_cnt);
    end
    $display("async reset in ERROR: ctl=%b to=%b", ctl, mem_timeout);
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(5'd6, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
      #1;
      n_checks++;
      if (stall_cnt !== CNT_W'((i < CMAX) ? i : CMAX)) begin
        n_fail++; $display("FAIL stall_sat_%0d: sc=%0d required %0d", i, stall_cnt, (i < CMAX) ? i : CMAX);
      end
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
      #1;
      n_checks++;
      if (flush_cnt !== CNT_W'((i < CMAX) ? i : CMAX) || stall_cnt !== CNT_W'(CMAX)) begin
        n_fail++; $display("FAIL flush_sat_%0d: fc=%0d sc=%0d required fc=%0d sc=%0d", i, flush_cnt, stall_cnt, (i < CMAX) ? i : CMAX, CMAX);
      end
    end
    $display("saturation: sc=%0d fc=%0d", stall_cnt, flush_cnt);
  endtask

  // Reference model: "how many cycles has the current memory access been
  // outstanding", an error flag, and plain saturating integers.
  task automatic test_random();
    int m_wait = 0, m_err_cycles = 0, m_scnt = 0, m_fcnt = 0;
    bit m_err = 0;
    logic [4:0] exp_ctl;
    logic [4:0] rs1, rs2, rd;
    logic u1, u2, rw, redir, mreq, rdy, lu;
    logic [1:0] rsrc;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
      rd = 5'($urandom_range(0, 3));
      u1 = 1'($urandom); u2 = 1'($urandom); rw = 1'($urandom);
      rsrc = 2'($urandom_range(0, 3));
      redir = ($urandom_range(0, 7) == 0);
      mreq = ($urandom_range(0, 2) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      drive(rs1, rs2, u1, u2, rd, rw, rsrc, redir, mreq, rdy);
      lu = (rsrc == 2'b01) && rw && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
      if (m_err)                   exp_ctl = C_STALL;
      else if (m_wait > 0)         exp_ctl = rdy ? C_NONE : C_STALL;
      else if (redir)              exp_ctl = C_FLUSH;
      else if (mreq && !rdy)       exp_ctl = C_STALL;
      else if (lu)                 exp_ctl = C_LU;
      else                         exp_ctl = C_NONE;
      #1;
      n_checks++;
      if (ctl !== exp_ctl || mem_timeout !== m_err ||
          stall_cnt !== CNT_W'(m_scnt) || flush_cnt !== CNT_W'(m_fcnt)) begin
        n_fail++;
        $display("FAIL random_%0d: ctl=%b to=%b sc=%0d fc=%0d required ctl=%b to=%b sc=%0d fc=%0d",
                 n, ctl, mem_timeout, stall_cnt, flush_cnt, exp_ctl, m_err, m_scnt, m_fcnt);
      end
      $display("random %0d: redir=%b mreq=%b rdy=%b lu=%b ctl=%b to=%b", n, redir, mreq, rdy, lu, ctl, mem_timeout);
      // Advance model
      if (exp_ctl[4] && m_scnt < CMAX) m_scnt++;
      if (exp_ctl == C_FLUSH && m_fcnt < CMAX) m_fcnt++;
      if (m_err) begin
        m_err_cycles++;
      end else if (m_wait > 0) begin
        if (rdy) m_wait = 0;
        else begin
          m_wait++;
          if (m_wait == MEM_TIMEOUT) begin m_err = 1; m_wait = 0; end
        end
      end else if (!redir && mreq && !rdy) begin
        m_wait = 1;
      end
      if (m_err && m_err_cycles >= 3) begin
        do_reset();
        m_err = 0; m_err_cycles = 0; m_wait = 0; m_scnt = 0; m_fcnt = 0;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_load_use();
    test_no_hazard();
    test_redirect_priority();
    test_mem_wait();
    test_timeout();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard and sequencing controller that generates the stall/flush controls consumed by the IF/ID and ID/EX pipeline registers and the PC register. It observes decode-stage source registers, the ID/EX register's outputs, and the data-memory handshake. It resolves load-use bubbles, EX-stage control-flow redirects, and multi-cycle memory waits. It also keeps saturating stall/flush performance counters and a sticky memory-timeout flag.

Parameters:
CNT_W, 32, width of stall_cnt and flush_cnt.
MEM_TIMEOUT, 16, maximum MEM_WAIT cycles before a timeout is declared (valid range ≥2).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
id_rs1  in  5  decode-stage rs1 index
id_rs2  in  5  decode-stage rs2 index
id_uses_rs1  in  1  decode instruction reads rs1
id_uses_rs2  in  1  decode instruction reads rs2
ex_rd  in  5  ID/EX destination register
ex_reg_write  in  1  ID/EX reg-write flag
ex_result_src  in  2  ID/EX result-source select; 2'b01 = load
ex_redirect  in  1  branch taken or jump/jalr resolved in EX this cycle
mem_req  in  1  EX/MEM instruction is accessing data memory this cycle
dmem_ready  in  1  data memory completes access this cycle
stall_pc  out  1  hold PC
stall_if_id  out  1  hold IF/ID register
flush_if_id  out  1  clear IF/ID register
stall_id_ex  out  1  hold ID/EX register
flush_id_ex  out  1  clear ID/EX register (insert bubble)
mem_timeout  out  1  sticky memory-timeout error
stall_cnt  out  CNT_W  cycles with stall_pc asserted, saturating
flush_cnt  out  CNT_W  redirect flush events, saturating

Behaviour:
- Reset (async, rst=1): state=RUN, wait timer=0, mem_timeout=0, stall_cnt=0, flush_cnt=0. All five control outputs are forced to 0 while rst is high.
- Control outputs are combinational from state and current inputs. Counters, timer, state and mem_timeout are registered.
- Load-use condition (LU): ex_result_src==2'b01 && ex_reg_write && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)).
- Invariant: stall_id_ex and flush_id_ex are never both 1. flush_if_id and stall_if_id are never both 1.
- State RUN, priority high to low:
  1. ex_redirect=1: flush_if_id=1, flush_id_ex=1, no stalls; flush_cnt+1; stay RUN. A concurrent LU or mem_req is ignored.
  2. mem_req && !dmem_ready: stall_pc=stall_if_id=stall_id_ex=1; next state MEM_WAIT; timer<=1.
  3. LU: stall_pc=1, stall_if_id=1, flush_id_ex=1 (one-cycle bubble); stay RUN. LU clears naturally the next cycle because the bubble has rd=0.
  4. Otherwise all controls are 0.
  - mem_req && dmem_ready in RUN is a single-cycle access: no stall.
- State MEM_WAIT: stall_pc=stall_if_id=stall_id_ex=1 and no flushes. ex_redirect and LU are ignored.
  - dmem_ready=1: all stalls deassert in that same cycle; next state RUN.
  - Else if timer==MEM_TIMEOUT-1: next state ERROR; mem_timeout<=1.
  - Else timer+1.
- State ERROR: stall_pc=stall_if_id=stall_id_ex=1 permanently; mem_timeout=1; exits only via rst.
- stall_cnt increments every cycle stall_pc=1, including MEM_WAIT and ERROR. flush_cnt increments only on redirect cycles. Both hold at all-ones (no wrap).
- Reset mid-MEM_WAIT or in ERROR: immediate return to RUN with all outputs cleared.

Test Plan:
- Load-use: ex_result_src=01, ex_reg_write=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 → same cycle stall_pc=stall_if_id=flush_id_ex=1, stall_id_ex=0. Next cycle, with ex_rd=0, all controls are 0 and stall_cnt=1.
- x0/no-use: the same setup with ex_rd=0, or with id_uses_rs1=0 → no stall or flush, counters unchanged.
- Redirect priority: ex_redirect=1 together with the LU condition → flush_if_id=flush_id_ex=1, all stalls 0, flush_cnt=1, stall_cnt=0.
- Memory wait: mem_req=1 with dmem_ready low for 3 cycles, then high → stalls asserted for exactly 3 cycles and deasserted in the ready cycle, state returns to RUN, stall_cnt=3.
- Timeout: MEM_TIMEOUT=4, mem_req=1, dmem_ready held 0 → mem_timeout=1 after cycle 4, stalls stay high through 10 more cycles. Asserting rst mid-operation clears all outputs immediately (asynchronous).
- Saturation: CNT_W=4, hold the stall for 20 cycles → stall_cnt stops at 15 and never wraps to 0.
